// File: rtl/sprite_cmd_pkg.sv
// Shared command-word layout, request record and encoder state type for the
// sprite command encoder.
package sprite_cmd_pkg;

  localparam int SUB_LSB   = 26;
  localparam int SUB_W     = 6;
  localparam int CHILD_LSB = 21;
  localparam int CHILD_W   = 5;
  localparam int INFO_LSB  = 17;
  localparam int INFO_W    = 4;
  localparam int TYPE_LSB  = 14;
  localparam int TYPE_W    = 3;
  localparam int PP_BIT    = 13;
  localparam int MSG_W     = 13;

  localparam logic [INFO_W-1:0] INFO_WRITE = 4'b0001;
  localparam logic [INFO_W-1:0] INFO_FLUSH = 4'b1111;
  localparam logic [INFO_W-1:0] INFO_IDLE  = 4'b0000;

  localparam logic [TYPE_W-1:0] TYPE_ATTR  = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_X     = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_Y     = 3'b011;
  localparam logic [TYPE_W-1:0] TYPE_SHIFT = 3'b100;

  typedef struct packed {
    logic [5:0] sub_comp;
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } sprite_req_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ATTR, ST_XPOS, ST_YPOS, ST_SHIFT, ST_FLUSH
  } enc_state_t;

  // Word emitted while sitting in state st; any non-word state yields idle.
  function automatic logic [31:0] cmd_word(enc_state_t st, sprite_req_t r, logic pp);
    logic [31:0]       w;
    logic [TYPE_W-1:0] typ;
    logic [MSG_W-1:0]  msg;
    w   = '0;
    typ = TYPE_ATTR;
    msg = '0;
    w[INFO_LSB +: INFO_W] = INFO_IDLE;
    case (st)
      ST_ATTR:  begin typ = TYPE_ATTR;  msg = {r.visible, r.flip, 6'b0, r.pattern}; end
      ST_XPOS:  begin typ = TYPE_X;     msg = {3'b0, r.x};                          end
      ST_YPOS:  begin typ = TYPE_Y;     msg = {3'b0, r.y};                          end
      ST_SHIFT: begin typ = TYPE_SHIFT; msg = {3'b0, r.shift};                      end
      default:  ;
    endcase
    case (st)
      ST_ATTR, ST_XPOS, ST_YPOS, ST_SHIFT: begin
        w[SUB_LSB +: SUB_W]     = r.sub_comp;
        w[CHILD_LSB +: CHILD_W] = r.child;
        w[INFO_LSB +: INFO_W]   = INFO_WRITE;
        w[TYPE_LSB +: TYPE_W]   = typ;
        w[PP_BIT]               = pp;
        w[0 +: MSG_W]           = msg;
      end
      ST_FLUSH: begin
        w[INFO_LSB +: INFO_W] = INFO_FLUSH;
        w[PP_BIT]             = pp;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sprite_req_fifo.sv
// Synchronous request FIFO for the sprite command encoder; a pop in the same
// cycle frees a slot, so push-while-full is accepted when paired with a pop.
module sprite_req_fifo
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  sprite_req_t push_data,
  input  logic        pop,
  output sprite_req_t head,
  output logic        full,
  output logic        empty
);

  sprite_req_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Serialises sprite update requests into back-buffer command words and issues
// the buffer-swap flush on commit. Define SPRITE_ENC_GAP_EN for an idle word
// after every non-idle word.
//
// state    | meaning
// IDLE     | nothing in flight; idle word on the bus
// ATTR     | attribute word of the held request
// XPOS     | x-position word
// YPOS     | y-position word
// SHIFT    | shift word; next request follows back-to-back
// FLUSH    | buffer-swap word; back_buf toggles on exit
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_sub_comp,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [4:0]  req_pattern,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_shift,
  input  logic        commit,
  output logic        commit_busy,
  output logic        back_buf,
  output logic [31:0] writedata
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  sprite_req_t req_in;
  sprite_req_t hold;
  sprite_req_t fifo_head;
  enc_state_t  state;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        run_q;
  logic        commit_pending;
  logic        advance;
  logic        flush_done;

  assign req_in = {req_sub_comp, req_child, req_visible, req_flip,
                   req_pattern, req_x, req_y, req_shift};

  // run_q keeps req_ready low while reset is held.
  assign req_ready   = run_q && !fifo_full && !commit_pending;
  assign fifo_push   = req_valid && req_ready;
  assign fifo_pop    = !fifo_empty && (state == ST_IDLE || (state == ST_SHIFT && advance));
  assign commit_busy = commit_pending;
  assign flush_done  = (state == ST_FLUSH) && advance;

`ifdef SPRITE_ENC_GAP_EN
  logic gap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_q <= 1'b0;
    else        gap_q <= (state != ST_IDLE) && !gap_q;
  end

  assign advance = gap_q;
`else
  assign advance = 1'b1;
`endif

  sprite_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (req_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q          <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      run_q <= 1'b1;
      // A commit arriving while one is pending merges into it.
      if (flush_done)  commit_pending <= 1'b0;
      else if (commit) commit_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold      <= '0;
      back_buf  <= 1'b1;
      writedata <= '0;
    end else if (state != ST_IDLE && !advance) begin
      writedata <= cmd_word(ST_IDLE, hold, back_buf);
    end else begin
      case (state)
        ST_IDLE, ST_SHIFT: begin
          if (!fifo_empty) begin
            hold      <= fifo_head;
            state     <= ST_ATTR;
            writedata <= cmd_word(ST_ATTR, fifo_head, back_buf);
          end else if (commit_pending) begin
            state     <= ST_FLUSH;
            writedata <= cmd_word(ST_FLUSH, hold, back_buf);
          end else begin
            state     <= ST_IDLE;
            writedata <= cmd_word(ST_IDLE, hold, back_buf);
          end
        end
        ST_ATTR: begin
          state     <= ST_XPOS;
          writedata <= cmd_word(ST_XPOS, hold, back_buf);
        end
        ST_XPOS: begin
          state     <= ST_YPOS;
          writedata <= cmd_word(ST_YPOS, hold, back_buf);
        end
        ST_YPOS: begin
          state     <= ST_SHIFT;
          writedata <= cmd_word(ST_SHIFT, hold, back_buf);
        end
        ST_FLUSH: begin
          state     <= ST_IDLE;
          back_buf  <= !back_buf;
          writedata <= cmd_word(ST_IDLE, hold, back_buf);
        end
        default: begin
          state     <= ST_IDLE;
          writedata <= cmd_word(ST_IDLE, hold, back_buf);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Bench for sprite_cmd_encoder: queue-based word-stream model checked every
// cycle, directed scenarios with literal words, then randomized traffic.
`timescale 1ns/1ps
module tb_sprite_cmd_encoder;
  import sprite_cmd_pkg::*;

  localparam int DEPTH = 8;
`ifdef SPRITE_ENC_GAP_EN
  localparam bit GAP = 1'b1;
  logic [31:0] t1_exp [8] = '{32'h0C427002, 32'h0, 32'h0C42A064, 32'h0,
                              32'h0C42E028, 32'h0, 32'h0C432000, 32'h0};
`else
  localparam bit GAP = 1'b0;
  logic [31:0] t1_exp [5] = '{32'h0C427002, 32'h0C42A064, 32'h0C42E028,
                              32'h0C432000, 32'h0};
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        commit = 1'b0;
  sprite_req_t drv = '0;
  logic        req_ready;
  logic        commit_busy;
  logic        back_buf;
  logic [31:0] writedata;

  sprite_cmd_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sub_comp (drv.sub_comp),
    .req_child    (drv.child),
    .req_visible  (drv.visible),
    .req_flip     (drv.flip),
    .req_pattern  (drv.pattern),
    .req_x        (drv.x),
    .req_y        (drv.y),
    .req_shift    (drv.shift),
    .commit       (commit),
    .commit_busy  (commit_busy),
    .back_buf     (back_buf),
    .writedata    (writedata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  bit saw_block = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending requests, remaining words of the current
  // sequence, and the frame/commit bookkeeping.
  sprite_req_t req_q[$];
  logic [31:0] out_q[$];
  bit          m_pend = 0, m_bb = 1, m_run = 0, m_flushing = 0;
  logic [31:0] m_wd = 0;

  function automatic logic [31:0] write_word(sprite_req_t r, int kind, bit pp);
    logic [31:0] msg;
    case (kind)
      1:       msg = 32'(r.visible) * 4096 + 32'(r.flip) * 2048 + 32'(r.pattern);
      2:       msg = 32'(r.x);
      3:       msg = 32'(r.y);
      default: msg = 32'(r.shift);
    endcase
    return (32'(r.sub_comp) << 26) + (32'(r.child) << 21) + (32'h1 << 17)
         + (32'(kind) << 14) + (32'(pp) << 13) + msg;
  endfunction

  function automatic logic [31:0] flush_word(bit pp);
    return (32'hF << 17) + (32'(pp) << 13);
  endfunction

  function automatic bit m_ready();
    return m_run && (req_q.size() < DEPTH) && !m_pend;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit acc, cleared;
    sprite_req_t r;
    if (!reset) begin
      req_q.delete(); out_q.delete();
      m_pend = 0; m_bb = 1; m_run = 0; m_flushing = 0; m_wd = 0;
    end else begin
      acc = req_valid && m_ready();
      cleared = 0;
      if (out_q.size() > 0) m_wd = out_q.pop_front();
      else if (m_flushing) begin
        m_wd = 0; m_bb = !m_bb; m_pend = 0; m_flushing = 0; cleared = 1;
      end else if (req_q.size() > 0) begin
        r = req_q.pop_front();
        m_wd = write_word(r, 1, m_bb);
        for (int k = 2; k <= 4; k++) begin
          if (GAP) out_q.push_back(32'h0);
          out_q.push_back(write_word(r, k, m_bb));
        end
        if (GAP) out_q.push_back(32'h0);
      end else if (m_pend) begin
        m_wd = flush_word(m_bb);
        if (GAP) out_q.push_back(32'h0);
        m_flushing = 1;
      end else m_wd = 0;
      if (acc) req_q.push_back(drv);
      if (commit && !cleared) m_pend = 1;
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      cmp("writedata", writedata, m_wd);
      cmp("req_ready", 32'(req_ready), 32'(m_ready()));
      cmp("commit_busy", 32'(commit_busy), 32'(m_pend));
      cmp("back_buf", 32'(back_buf), 32'(m_bb));
    end
  end

  function automatic sprite_req_t rand_req();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic send(input sprite_req_t r);
    int tries = 0;
    drv = r;
    req_valid = 1'b1;
    while (!req_ready && tries < 200) begin
      saw_block = 1'b1;
      @(negedge clk);
      tries++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: req_ready stuck at %b, expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3 reset = 1'b0;
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_writedata", writedata, 32'h0);
    cmp("rst_back_buf", 32'(back_buf), 32'd1);
    cmp("rst_busy", 32'(commit_busy), 32'd0);
    cmp("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single request, literal words
    send('{sub_comp: 6'd3, child: 5'd2, visible: 1'b1, flip: 1'b0, pattern: 5'd2,
           x: 10'd100, y: 10'd40, shift: 10'd0});
    foreach (t1_exp[i]) begin
      @(negedge clk);
      cmp("t1_word", writedata, t1_exp[i]);
    end

    // commit with empty FIFO
    pulse_commit();
    cmp("t2_busy", 32'(commit_busy), 32'd1);
    @(negedge clk);
    cmp("t2_flush", writedata, 32'h001E2000);
    repeat (3) @(negedge clk);
    cmp("t2_back_buf", 32'(back_buf), 32'd0);
    cmp("t2_busy_clr", 32'(commit_busy), 32'd0);
    send(rand_req());
    @(negedge clk);
    cmp("t2_pp_selc", 32'(writedata[13]), 32'd0);
    cmp("t2_info", 32'(writedata[20:17]), 32'd1);
    repeat (12) @(negedge clk);

    // overfill the FIFO while the FSM is busy
    saw_block = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) send(rand_req());
    cmp("t3_full_seen", 32'(saw_block), 32'd1);
    repeat ((DEPTH + 4) * 8 + 10) @(negedge clk);

    // commit with requests queued, then a held request
    for (int i = 0; i < 4; i++) send(rand_req());
    pulse_commit();
    cmp("t4_ready_blocked", 32'(req_ready), 32'd0);
    send(rand_req());
    repeat (24) @(negedge clk);
    cmp("t4_back_buf", 32'(back_buf), 32'd1);

    // reset during YPOS
    pulse_commit();
    repeat (8) @(negedge clk);
    cmp("t5_pre_bb", 32'(back_buf), 32'd0);
    send(rand_req());
    repeat (GAP ? 4 : 2) @(negedge clk);
    @(posedge clk);
    #1;
    cmp("t5_in_ypos", 32'(writedata[16:14]), 32'd3);
    #1 reset = 1'b0;
    #1;
    cmp("t5_rst_wd", writedata, 32'h0);
    cmp("t5_rst_bb", 32'(back_buf), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    cmp("t5_idle_after", writedata, 32'h0);
    cmp("t5_ready_after", 32'(req_ready), 32'd1);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      drv = rand_req();
      commit = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    commit = 1'b0;
    repeat (80) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
